// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : unidad_control_multiciclo
// Purpose  : Multi-cycle MIPS control FSM. Fetch and data accesses share one
//            memory port. Decodes the opcode, sequences one micro-step per
//            clock, waits on the mem_ready handshake and flags a memory
//            timeout when the wait exceeds TIMEOUT cycles.
// Options  : UCM_PERF_CNT_EN - adds cycle_cnt / inst_cnt performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module unidad_control_multiciclo #(
  parameter int TIMEOUT = 15   // max cycles waiting on mem_ready (1..255)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemReg,
  output logic        IRWrite,
  output logic [1:0]  PCSource,
  output logic [2:0]  AluOp,
  output logic        AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        err_timeout,
  output logic        illegal_op,
`ifdef UCM_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt,
`endif
  output logic [3:0]  state
);

  // --------------------------------------------------------------------------
  // State encoding (visible on the state debug port)
  // --------------------------------------------------------------------------
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR = 4'd3;
  localparam logic [3:0] ST_MEM_RD   = 4'd4;
  localparam logic [3:0] ST_MEM_WB   = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_EXEC     = 4'd7;
  localparam logic [3:0] ST_R_WB     = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_JUMP     = 4'd10;
  localparam logic [3:0] ST_ADDI_EX  = 4'd11;
  localparam logic [3:0] ST_ADDI_WB  = 4'd12;

  // --------------------------------------------------------------------------
  // Supported opcodes
  // --------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // --------------------------------------------------------------------------
  // Datapath encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // --------------------------------------------------------------------------
  // Wait counter sizing: must be able to hold the value TIMEOUT itself
  // --------------------------------------------------------------------------
  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [3:0]       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             in_mem_state;
  logic             timeout_hit;

  // Memory states are the only ones that wait on the handshake.
  assign in_mem_state = (state == ST_FETCH) || (state == ST_MEM_RD) ||
                        (state == ST_MEM_WR);

  // A late mem_ready on the last allowed cycle still wins over the timeout.
  assign timeout_hit = in_mem_state && !mem_ready && (wait_cnt == TIMEOUT_CNT);

  // State register; asynchronous reset parks the FSM in IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: sequencing, opcode dispatch and timeout abort.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: next_state = ST_FETCH;

      ST_FETCH: begin
        if (mem_ready)        next_state = ST_DECODE;
        else if (timeout_hit) next_state = ST_IDLE;
        else                  next_state = ST_FETCH;
      end

      ST_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_RTYPE:     next_state = ST_EXEC;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_JUMP:      next_state = ST_JUMP;
          OP_ADDI:      next_state = ST_ADDI_EX;
          default:      next_state = ST_FETCH;
        endcase
      end

      // IR is held (IRWrite=0), so OpCode still identifies lw vs sw here.
      ST_MEM_ADDR: next_state = (OpCode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;

      ST_MEM_RD: begin
        if (mem_ready)        next_state = ST_MEM_WB;
        else if (timeout_hit) next_state = ST_IDLE;
        else                  next_state = ST_MEM_RD;
      end

      ST_MEM_WB: next_state = ST_FETCH;

      ST_MEM_WR: begin
        if (mem_ready)        next_state = ST_FETCH;
        else if (timeout_hit) next_state = ST_IDLE;
        else                  next_state = ST_MEM_WR;
      end

      ST_EXEC:    next_state = ST_R_WB;
      ST_R_WB:    next_state = ST_FETCH;
      ST_BRANCH:  next_state = ST_FETCH;
      ST_JUMP:    next_state = ST_FETCH;
      ST_ADDI_EX: next_state = ST_ADDI_WB;
      ST_ADDI_WB: next_state = ST_FETCH;

      // Unused codes recover to IDLE.
      default:    next_state = ST_IDLE;
    endcase
  end

  // Wait counter next value: counts only while stalled in the same memory
  // state; any handshake, state change or entry into a memory state clears it.
  always_comb begin
    wait_cnt_next = '0;
    if (in_mem_state && (next_state == state)) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end

  // Output decode: datapath controls as a function of state (and mem_ready
  // in FETCH so IR/PC only load on a completed fetch).
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemReg      = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    AluOp       = ALU_ADD;
    AluSrcA     = 1'b0;
    AluSrcB     = SRCB_REG;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      ST_FETCH: begin
        MemRead  = 1'b1;
        IorD     = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = SRCB_FOUR;
        AluOp    = ALU_ADD;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut while decoding.
        AluSrcA = 1'b0;
        AluSrcB = SRCB_IMM4;
        AluOp   = ALU_ADD;
        case (OpCode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_JUMP, OP_ADDI: illegal_op = 1'b0;
          default:                                          illegal_op = 1'b1;
        endcase
      end
      ST_MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        AluOp   = ALU_ADD;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemReg   = 1'b1;
        RegDst   = 1'b0;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_REG;
        AluOp   = ALU_FUNCT;
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ST_BRANCH: begin
        AluSrcA     = 1'b1;
        AluSrcB     = SRCB_REG;
        AluOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      ST_ADDI_EX: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        AluOp   = ALU_ADD;
      end
      ST_ADDI_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b0;
      end
      default: begin
        // IDLE and unused codes keep every control deasserted.
      end
    endcase
  end

`ifdef UCM_PERF_CNT_EN
  // Performance counters: active cycles and completed instruction fetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      inst_cnt  <= 32'd0;
    end else begin
      if (state != ST_IDLE) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if ((state == ST_FETCH) && (next_state == ST_DECODE)) begin
        inst_cnt <= inst_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidad_control_multiciclo
// Purpose  : Self-checking bench for unidad_control_multiciclo. A table of
//            per-cycle {OpCode, mem_ready, expected state, expected controls}
//            records walks every instruction class, followed by hand-written
//            sequences for timeout, last-cycle handshake and async reset.
// Options  : UCM_PERF_CNT_EN - also connects and checks inst_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidad_control_multiciclo;

  logic        clk;
  logic        reset;
  logic [5:0]  OpCode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemReg, IRWrite;
  logic [1:0]  PCSource;
  logic [2:0]  AluOp;
  logic        AluSrcA;
  logic [1:0]  AluSrcB;
  logic        RegWrite, RegDst, err_timeout, illegal_op;
  logic [3:0]  state;
`ifdef UCM_PERF_CNT_EN
  logic [31:0] cycle_cnt, inst_cnt;
`endif

  unidad_control_multiciclo #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReg(MemReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .AluOp(AluOp),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .err_timeout(err_timeout), .illegal_op(illegal_op),
`ifdef UCM_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt),
`endif
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite MemReg IRWrite
  //              PCSource AluOp AluSrcA AluSrcB RegWrite RegDst illegal_op
  logic [17:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemReg, IRWrite,
                 PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst, illegal_op};

  localparam logic [17:0] C_IDLE    = 18'b0_0_0_0_0_0_0_00_000_0_00_0_0_0;
  localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_0_0_1_00_000_0_01_0_0_0;
  localparam logic [17:0] C_FETCH_W = 18'b0_0_0_1_0_0_0_00_000_0_01_0_0_0;
  localparam logic [17:0] C_DEC     = 18'b0_0_0_0_0_0_0_00_000_0_11_0_0_0;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_00_000_0_11_0_0_1;
  localparam logic [17:0] C_MADDR   = 18'b0_0_0_0_0_0_0_00_000_1_10_0_0_0;
  localparam logic [17:0] C_MRD     = 18'b0_0_1_1_0_0_0_00_000_0_00_0_0_0;
  localparam logic [17:0] C_MWB     = 18'b0_0_0_0_0_1_0_00_000_0_00_1_0_0;
  localparam logic [17:0] C_MWR     = 18'b0_0_1_0_1_0_0_00_000_0_00_0_0_0;
  localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_00_010_1_00_0_0_0;
  localparam logic [17:0] C_RWB     = 18'b0_0_0_0_0_0_0_00_000_0_00_1_1_0;
  localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_01_001_1_00_0_0_0;
  localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_10_000_0_00_0_0_0;
  localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_00_000_0_00_1_0_0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vq[$];
  int   errors;
  int   checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic [17:0] ctl);
    vq.push_back('{op: op, rdy: rdy, st: st, ctl: ctl});
  endtask

  // Reset, release on a falling edge, and confirm the single IDLE cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; OpCode = OP_R; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_idle", {28'd0, state}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; OpCode = OP_R; mem_ready = 1'b1;

    // One row per clock cycle starting with the IDLE cycle after reset.
    add(OP_R,   1, 4'd0,  C_IDLE);
    add(OP_R,   1, 4'd1,  C_FETCH_R);
    add(OP_R,   1, 4'd2,  C_DEC);
    add(OP_R,   0, 4'd7,  C_EXEC);     // mem_ready ignored outside memory states
    add(OP_R,   0, 4'd8,  C_RWB);
    add(OP_LW,  1, 4'd1,  C_FETCH_R);  // lw with 3 stall cycles: 8 cycles
    add(OP_LW,  1, 4'd2,  C_DEC);
    add(OP_LW,  1, 4'd3,  C_MADDR);
    add(OP_LW,  0, 4'd4,  C_MRD);
    add(OP_LW,  0, 4'd4,  C_MRD);
    add(OP_LW,  0, 4'd4,  C_MRD);
    add(OP_LW,  1, 4'd4,  C_MRD);
    add(OP_LW,  1, 4'd5,  C_MWB);
    add(OP_SW,  0, 4'd1,  C_FETCH_W);  // sw with one fetch stall
    add(OP_SW,  1, 4'd1,  C_FETCH_R);
    add(OP_SW,  1, 4'd2,  C_DEC);
    add(OP_SW,  1, 4'd3,  C_MADDR);
    add(OP_SW,  1, 4'd6,  C_MWR);
    add(OP_BEQ, 1, 4'd1,  C_FETCH_R);
    add(OP_BEQ, 1, 4'd2,  C_DEC);
    add(OP_BEQ, 1, 4'd9,  C_BRANCH);
    add(OP_J,   1, 4'd1,  C_FETCH_R);
    add(OP_J,   1, 4'd2,  C_DEC);
    add(OP_J,   1, 4'd10, C_JUMP);
    add(OP_ADI, 1, 4'd1,  C_FETCH_R);
    add(OP_ADI, 1, 4'd2,  C_DEC);
    add(OP_ADI, 1, 4'd11, C_MADDR);
    add(OP_ADI, 1, 4'd12, C_ADDIWB);
    add(OP_BAD, 1, 4'd1,  C_FETCH_R);
    add(OP_BAD, 1, 4'd2,  C_DEC_ILL);  // illegal opcode pulse
    add(OP_R,   1, 4'd1,  C_FETCH_R);  // back to FETCH directly
    add(OP_R,   1, 4'd2,  C_DEC);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_ctrl",  {14'd0, ctrl},  32'd0);
    check("reset_err",   {31'd0, err_timeout}, 32'd0);
`ifdef UCM_PERF_CNT_EN
    check("reset_inst_cnt", inst_cnt, 32'd0);
`endif

    // ---------------- table-driven walk ----------------
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      OpCode = vq[i].op; mem_ready = vq[i].rdy;
      #1;
      check($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vq[i].st});
      check($sformatf("vec%0d_ctrl", i),  {14'd0, ctrl},  {14'd0, vq[i].ctl});
      check($sformatf("vec%0d_err", i),   {31'd0, err_timeout}, 32'd0);
      @(negedge clk);
    end

    // ---------------- fetch timeout ----------------
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      check($sformatf("to_fetch%0d", k), {28'd0, state}, 32'd1);
      check($sformatf("to_noerr%0d", k), {31'd0, err_timeout}, 32'd0);
    end
    @(negedge clk); #1;
    check("to_idle",  {28'd0, state}, 32'd0);
    check("to_err",   {31'd0, err_timeout}, 32'd1);
    check("to_ctrl",  {14'd0, ctrl}, 32'd0);
    @(negedge clk); mem_ready = 1'b1; #1;
    check("to_refetch", {28'd0, state}, 32'd1);
    check("to_sticky1", {31'd0, err_timeout}, 32'd1);
    @(negedge clk); #1;
    check("to_decode",  {28'd0, state}, 32'd2);
    check("to_sticky2", {31'd0, err_timeout}, 32'd1);
    #2 reset = 1'b1; #1;
    check("to_rst_err",   {31'd0, err_timeout}, 32'd0);
    check("to_rst_state", {28'd0, state}, 32'd0);

    // ---------------- handshake on the last allowed cycle ----------------
    do_reset();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      check($sformatf("lc_fetch%0d", k), {28'd0, state}, 32'd1);
    end
    @(negedge clk); mem_ready = 1'b1; OpCode = OP_LW; #1;
    check("lc_fetch_last", {28'd0, state}, 32'd1);
    check("lc_fetch_ctrl", {14'd0, ctrl}, {14'd0, C_FETCH_R});
    @(negedge clk); #1;
    check("lc_decode", {28'd0, state}, 32'd2);
    check("lc_noerr",  {31'd0, err_timeout}, 32'd0);
    @(negedge clk); #1;
    check("lc_maddr", {28'd0, state}, 32'd3);
    mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      check($sformatf("lc_mrd%0d", k), {28'd0, state}, 32'd4);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    check("lc_mrd_last", {28'd0, state}, 32'd4);
    @(negedge clk); #1;
    check("lc_mwb",    {28'd0, state}, 32'd5);
    check("lc_mwb_ctl", {14'd0, ctrl}, {14'd0, C_MWB});
    check("lc_noerr2", {31'd0, err_timeout}, 32'd0);

    // ---------------- async reset during MEM_WR ----------------
    do_reset();
    mem_ready = 1'b1; OpCode = OP_SW;
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("ar_mwr_state", {28'd0, state}, 32'd6);
    check("ar_mwr_memw",  {31'd0, MemWrite}, 32'd1);
    #2 reset = 1'b1; #1;
    check("ar_state",  {28'd0, state}, 32'd0);
    check("ar_ctrl",   {14'd0, ctrl}, 32'd0);
    check("ar_memw",   {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; #1;
    check("ar_idle", {28'd0, state}, 32'd0);
`ifdef UCM_PERF_CNT_EN
    check("ar_inst_cnt", inst_cnt, 32'd0);
`endif
    @(negedge clk); #1;
    check("ar_fetch", {28'd0, state}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
